// File: rtl/gbt_pll_ctrl_pkg.sv
// Shared types and defaults for the GBT TX frame-clock PLL reset/lock sequencer.
package gbt_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST_ASSERT = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABILIZE  = 3'd2,
        ST_READY      = 3'd3,
        ST_FAULT      = 3'd4
    } pll_state_e;

    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 120000;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_MAX_RETRIES   = 4;
    localparam int unsigned DEF_CNT_W         = 20;

    localparam int unsigned LOL_CNT_W = 8;
    localparam int unsigned RETRY_W   = 3;

endpackage

// File: rtl/gbt_bit_sync.sv
// Generic two-flop synchronizer for a single asynchronous status bit; resets to 0.
module gbt_bit_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gbt_tx_frameclk_pll_ctrl.sv
// Reset/lock sequencer for the GBT TX frame-clock PLL: timed reset, lock wait with
// timeout and bounded retries, stability qualification and loss-of-lock accounting.
module gbt_tx_frameclk_pll_ctrl
    import gbt_pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic                 relock_req,
    output logic                 pll_rst,
    output logic                 ready,
    output logic                 error,
    output logic [RETRY_W-1:0]   retry_cnt,
    output logic [LOL_CNT_W-1:0] lol_cnt,
    output logic [2:0]           state
);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    logic                 lock_sync;
    pll_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [LOL_CNT_W-1:0] lol_q, lol_d;
    logic                 pll_rst_q, ready_q, error_q;

    gbt_bit_sync u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (lock_sync)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lol_d   = lol_q;

        // relock_req outranks every in-state event, including a coincident lock loss.
        if (relock_req && (state_q != ST_RST_ASSERT)) begin
            state_d = ST_RST_ASSERT;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RST_ASSERT: begin
                    if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync) begin
                        state_d = ST_STABILIZE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_q + 1'b1;
                        state_d = (retry_d == RETRY_LIMIT) ? ST_FAULT : ST_RST_ASSERT;
                    end
                end
                ST_STABILIZE: begin
                    if (!lock_sync) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_READY;
                        retry_d = '0;
                    end
                end
                ST_READY: begin
                    if (!lock_sync) begin
                        if (lol_q != '1) lol_d = lol_q + 1'b1;
                        retry_d = '0;
                        state_d = ST_RST_ASSERT;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_RST_ASSERT;
                end
            endcase
        end

        if ((state_d != state_q) || (state_q == ST_READY) || (state_q == ST_FAULT)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RST_ASSERT;
            cnt_q     <= '0;
            retry_q   <= '0;
            lol_q     <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lol_q     <= lol_d;
            pll_rst_q <= (state_d == ST_RST_ASSERT) || (state_d == ST_FAULT);
            ready_q   <= (state_d == ST_READY);
            error_q   <= (state_d == ST_FAULT);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign ready     = ready_q;
    assign error     = error_q;
    assign retry_cnt = retry_q;
    assign lol_cnt   = lol_q;
    assign state     = state_q;

endmodule

// File: tb/tb_gbt_tx_frameclk_pll_ctrl.sv
// Directed self-checking bench for gbt_tx_frameclk_pll_ctrl with small interval parameters.
module tb_gbt_tx_frameclk_pll_ctrl;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       ready;
    logic       error;
    logic [2:0] retry_cnt;
    logic [7:0] lol_cnt;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    gbt_tx_frameclk_pll_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (50),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .CNT_W         (20)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .error      (error),
        .retry_cnt  (retry_cnt),
        .lol_cnt    (lol_cnt),
        .state      (state)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Pulse rst for two edges; on return rst is low and the next edge is edge 1.
    task automatic do_reset();
        rst = 1'b1;
        relock_req = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic run_until_ready(input int max_cycles, output int n);
        n = 0;
        while (ready !== 1'b1 && n < max_cycles) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick(3);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (ready !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_ready_error: got %b%b expected 00", ready, error); end
        checks++; if (retry_cnt !== 3'd0 || lol_cnt !== 8'd0) begin errors++; $display("FAIL reset_counters: got retry=%0d lol=%0d expected 0 0", retry_cnt, lol_cnt); end
    endtask

    task automatic test_bringup();
        pll_locked = 1'b0;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            checks++;
            if (pll_rst !== (i < 4)) begin errors++; $display("FAIL bringup_pll_rst_e%0d: got %b expected %b", i, pll_rst, (i < 4)); end
        end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL bringup_wait_lock: got %0d expected 1", state); end
        tick(10);
        pll_locked = 1'b1;
        for (int i = 15; i <= 24; i++) begin
            tick(1);
            checks++;
            if (ready !== 1'b0) begin errors++; $display("FAIL bringup_early_ready_e%0d: got %b expected 0", i, ready); end
        end
        tick(1);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bringup_ready_e25: got %b expected 1", ready); end
        checks++; if (state !== 3'd3 || retry_cnt !== 3'd0 || pll_rst !== 1'b0) begin
            errors++; $display("FAIL bringup_ready_state: got state=%0d retry=%0d pll_rst=%b expected 3 0 0", state, retry_cnt, pll_rst);
        end
    endtask

    task automatic test_lol();
        int n;
        logic [7:0] exp_lol;
        exp_lol = 8'd0;
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            tick(2);
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lol_ready_held_%0d: got %b expected 1", i, ready); end
            tick(1);
            exp_lol = (exp_lol == 8'd255) ? 8'd255 : exp_lol + 8'd1;
            checks++; if (ready !== 1'b0 || pll_rst !== 1'b1 || state !== 3'd0) begin
                errors++; $display("FAIL lol_drop_%0d: got ready=%b pll_rst=%b state=%0d expected 0 1 0", i, ready, pll_rst, state);
            end
            checks++; if (lol_cnt !== exp_lol) begin errors++; $display("FAIL lol_count_%0d: got %0d expected %0d", i, lol_cnt, exp_lol); end
            pll_locked = 1'b1;
            run_until_ready(40, n);
            checks++; if (n !== 13) begin errors++; $display("FAIL lol_reready_%0d: got %0d cycles expected 13", i, n); end
        end
        checks++; if (lol_cnt !== 8'd255) begin errors++; $display("FAIL lol_saturate: got %0d expected 255", lol_cnt); end
    endtask

    task automatic test_mid_rst();
        int n;
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        n = 0;
        while (state !== 3'd2 && n < 40) begin
            tick(1);
            n++;
        end
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL midrst_reach_stabilize: got %0d expected 2", state); end
        rst = 1'b1;
        tick(1);
        checks++; if (state !== 3'd0 || pll_rst !== 1'b1 || ready !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got state=%0d pll_rst=%b ready=%b error=%b expected 0 1 0 0", state, pll_rst, ready, error);
        end
        checks++; if (lol_cnt !== 8'd0 || retry_cnt !== 3'd0) begin
            errors++; $display("FAIL midrst_counters: got lol=%0d retry=%0d expected 0 0", lol_cnt, retry_cnt);
        end
        tick(1);
        rst = 1'b0;
        tick(3);
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL midrst_pll_rst_e3: got %b expected 1", pll_rst); end
        tick(1);
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL midrst_pll_rst_e4: got %b expected 0", pll_rst); end
        tick(8);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_e12: got %b expected 0", ready); end
        tick(1);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_e13: got %b expected 1", ready); end
    endtask

    task automatic test_timeout();
        pll_locked = 1'b0;
        do_reset();
        tick(53);
        checks++; if (state !== 3'd1 || retry_cnt !== 3'd0) begin
            errors++; $display("FAIL timeout_pre1: got state=%0d retry=%0d expected 1 0", state, retry_cnt);
        end
        tick(1);
        checks++; if (state !== 3'd0 || retry_cnt !== 3'd1 || pll_rst !== 1'b1) begin
            errors++; $display("FAIL timeout_first: got state=%0d retry=%0d pll_rst=%b expected 0 1 1", state, retry_cnt, pll_rst);
        end
        tick(3);
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL timeout_pulse_hold: got %b expected 1", pll_rst); end
        tick(1);
        checks++; if (pll_rst !== 1'b0 || state !== 3'd1) begin
            errors++; $display("FAIL timeout_pulse_end: got pll_rst=%b state=%0d expected 0 1", pll_rst, state);
        end
        tick(49);
        checks++; if (state !== 3'd1 || retry_cnt !== 3'd1 || error !== 1'b0) begin
            errors++; $display("FAIL timeout_pre2: got state=%0d retry=%0d error=%b expected 1 1 0", state, retry_cnt, error);
        end
        tick(1);
        checks++; if (state !== 3'd4 || retry_cnt !== 3'd2 || error !== 1'b1 || pll_rst !== 1'b1) begin
            errors++; $display("FAIL timeout_fault: got state=%0d retry=%0d error=%b pll_rst=%b expected 4 2 1 1", state, retry_cnt, error, pll_rst);
        end
        tick(20);
        checks++; if (state !== 3'd4 || error !== 1'b1) begin
            errors++; $display("FAIL fault_hold: got state=%0d error=%b expected 4 1", state, error);
        end
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        checks++; if (state !== 3'd0 || error !== 1'b0 || retry_cnt !== 3'd0 || pll_rst !== 1'b1) begin
            errors++; $display("FAIL relock_fault: got state=%0d error=%b retry=%0d pll_rst=%b expected 0 0 0 1", state, error, retry_cnt, pll_rst);
        end
        tick(3);
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL relock_fault_pulse_hold: got %b expected 1", pll_rst); end
        tick(1);
        checks++; if (pll_rst !== 1'b0 || state !== 3'd1) begin
            errors++; $display("FAIL relock_fault_pulse_end: got pll_rst=%b state=%0d expected 0 1", pll_rst, state);
        end
    endtask

    task automatic test_glitch();
        pll_locked = 1'b0;
        do_reset();
        tick(4);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL glitch_stabilize: got %0d expected 2", state); end
        tick(1);
        checks++; if (state !== 3'd1 || retry_cnt !== 3'd0) begin
            errors++; $display("FAIL glitch_back_to_wait: got state=%0d retry=%0d expected 1 0", state, retry_cnt);
        end
        tick(1);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL glitch_restabilize: got %0d expected 2", state); end
        tick(7);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL glitch_ready_early: got %b expected 0", ready); end
        tick(1);
        checks++; if (ready !== 1'b1 || retry_cnt !== 3'd0) begin
            errors++; $display("FAIL glitch_ready: got ready=%b retry=%0d expected 1 0", ready, retry_cnt);
        end
    endtask

    task automatic test_relock_ready();
        int n;
        pll_locked = 1'b1;
        do_reset();
        run_until_ready(40, n);
        checks++; if (n !== 13) begin errors++; $display("FAIL relock_ready_initial: got %0d cycles expected 13", n); end
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        checks++; if (state !== 3'd0 || ready !== 1'b0 || pll_rst !== 1'b1 || lol_cnt !== 8'd0) begin
            errors++; $display("FAIL relock_ready: got state=%0d ready=%b pll_rst=%b lol=%0d expected 0 0 1 0", state, ready, pll_rst, lol_cnt);
        end
        tick(3);
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL relock_ready_pulse_hold: got %b expected 1", pll_rst); end
        tick(1);
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL relock_ready_pulse_end: got %b expected 0", pll_rst); end
        run_until_ready(40, n);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL relock_ready_again: got %b expected 1", ready); end
        pll_locked = 1'b0;
        tick(2);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        checks++; if (state !== 3'd0 || ready !== 1'b0 || lol_cnt !== 8'd0) begin
            errors++; $display("FAIL relock_vs_lol: got state=%0d ready=%b lol=%0d expected 0 0 0", state, ready, lol_cnt);
        end
        tick(1);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        tick(1);
        checks++; if (state !== 3'd0 || pll_rst !== 1'b1) begin
            errors++; $display("FAIL relock_in_rst_hold: got state=%0d pll_rst=%b expected 0 1", state, pll_rst);
        end
        tick(1);
        checks++; if (state !== 3'd1 || pll_rst !== 1'b0) begin
            errors++; $display("FAIL relock_in_rst_ignored: got state=%0d pll_rst=%b expected 1 0", state, pll_rst);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lol();
        test_mid_rst();
        test_timeout();
        test_glitch();
        test_relock_ready();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
